// File: rtl/disp_pkg.sv
// disp_pkg
// Shared types and constants for the display frame buffer slice.
//   color_t    : 2-bit pixel color codes (OFF, RED, YEL, BLU)
//   fb_state_t : frame buffer controller states (INIT, IDLE, CLEAR)
//   ROWS/COLS  : panel geometry, LINE_W bits per row word, HALF rows per panel half
//   fill_word  : replicates one pixel color across a full row word
package disp_pkg;

  localparam int ROWS   = 32;
  localparam int COLS   = 32;
  localparam int LINE_W = 64;
  localparam int HALF   = 16;

  typedef enum logic [1:0] {
    OFF = 2'b00,
    RED = 2'b01,
    YEL = 2'b10,
    BLU = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;

  function automatic logic [LINE_W-1:0] fill_word(input logic [1:0] color);
    return {COLS{color}};
  endfunction

endpackage

// File: rtl/fb_bank.sv
// fb_bank
// One frame buffer bank: NROWS row words of LW bits, 2 bits per pixel with
// column 0 at the LSB. Storage has no reset; the owner zeroes it row by row.
// Ports:
//   clk                         : clock
//   pix_we/pix_row/pix_col/pix_color : single-pixel write
//   row_we/row_addr/row_data    : full-row write (used for zeroing and fills)
//   rd_addr_a/rd_data_a         : combinational read port A
//   rd_addr_b/rd_data_b         : combinational read port B
module fb_bank
  import disp_pkg::*;
#(
  parameter int NROWS = ROWS,
  parameter int LW    = LINE_W
)
(
  input  logic          clk,
  input  logic          pix_we,
  input  logic [4:0]    pix_row,
  input  logic [4:0]    pix_col,
  input  logic [1:0]    pix_color,
  input  logic          row_we,
  input  logic [4:0]    row_addr,
  input  logic [LW-1:0] row_data,
  input  logic [4:0]    rd_addr_a,
  input  logic [4:0]    rd_addr_b,
  output logic [LW-1:0] rd_data_a,
  output logic [LW-1:0] rd_data_b
);

  logic [LW-1:0] mem [NROWS];

  // A row write replaces the whole word; the controller never asks for both
  // kinds of write in the same cycle, but the row write takes priority anyway.
  always_ff @(posedge clk) begin
    if (row_we) begin
      mem[row_addr] <= row_data;
    end else if (pix_we) begin
      mem[pix_row][{pix_col, 1'b0} +: 2] <= pix_color;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/board_framebuf.sv
// board_framebuf
// Double-buffered frame buffer serving upper/lower line pairs to the display
// line-fetch FSM, with pixel writes, flood clear and frame-aligned bank swap
// coming from the game logic.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   ren, raddr                : line read request; raddr[3:0] selects the row pair
//   Hline, Lline              : registered front-bank rows raddr[3:0] and raddr[3:0]+16
//   wr_en/wr_row/wr_col/wr_color : back-bank pixel write
//   clr_req, clr_color        : flood-fill the back bank
//   swap_req                  : request front/back exchange at the next frame start
//   busy                      : controller is zeroing (INIT) or filling (CLEAR)
//   swap_pend                 : swap requested, not yet committed
//   swap_done                 : one-cycle pulse on the commit cycle
module board_framebuf
  import disp_pkg::*;
#(
  parameter int ROWS = disp_pkg::ROWS,
  parameter int COLS = disp_pkg::COLS
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic [4:0]        raddr,
  output logic [2*COLS-1:0] Hline,
  output logic [2*COLS-1:0] Lline,
  input  logic              wr_en,
  input  logic [4:0]        wr_row,
  input  logic [4:0]        wr_col,
  input  logic [1:0]        wr_color,
  input  logic              clr_req,
  input  logic [1:0]        clr_color,
  input  logic              swap_req,
  output logic              busy,
  output logic              swap_pend,
  output logic              swap_done
);

  localparam int LW = 2 * COLS;

  localparam logic [1:0] ST_INIT  = INIT;
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CLEAR = CLEAR;

  logic [1:0]    state;
  logic [4:0]    rc;
  logic          front_sel;
  logic [LW-1:0] fill;

  logic          in_idle;
  logic          commit;
  logic          rd_sel;
  logic          back_sel;
  logic          pix_wr;
  logic          row_wr_init;
  logic          row_wr_clear;
  logic [LW-1:0] row_data;
  logic [4:0]    upper_row;
  logic [4:0]    lower_row;

  logic          b0_pix_we, b1_pix_we;
  logic          b0_row_we, b1_row_we;
  logic [LW-1:0] b0_rd_a, b0_rd_b, b1_rd_a, b1_rd_b;

  // The display only addresses row pairs; the top address bit is not a row select.
  logic unused_raddr_msb;
  assign unused_raddr_msb = raddr[4];

  assign in_idle = (state == ST_IDLE);
  assign busy    = !in_idle;

  // A swap lands only at the start of a frame (row pair 0 fetched) so the
  // display never shows half of one frame and half of the next.
  assign commit = in_idle && swap_pend && ren && (raddr[3:0] == 4'd0);

  // The fetch on the commit cycle already comes from the bank becoming front.
  assign rd_sel   = front_sel ^ commit;
  assign back_sel = !front_sel;

  // Back-bank writes use the pre-swap back bank, so a pixel written on the
  // commit cycle lands in the bank that is becoming front. A clear request
  // in the same cycle as a pixel write wins and the pixel is dropped.
  assign pix_wr       = !rst && in_idle && wr_en && !clr_req;
  assign row_wr_init  = !rst && (state == ST_INIT);
  assign row_wr_clear = !rst && (state == ST_CLEAR);
  assign row_data     = (state == ST_INIT) ? '0 : fill;

  assign b0_pix_we = pix_wr && (back_sel == 1'b0);
  assign b1_pix_we = pix_wr && (back_sel == 1'b1);
  assign b0_row_we = row_wr_init || (row_wr_clear && (back_sel == 1'b0));
  assign b1_row_we = row_wr_init || (row_wr_clear && (back_sel == 1'b1));

  assign upper_row = {1'b0, raddr[3:0]};
  assign lower_row = 5'(HALF) + {1'b0, raddr[3:0]};

  fb_bank #(
    .NROWS (ROWS),
    .LW    (LW)
  ) u_bank0 (
    .clk       (clk),
    .pix_we    (b0_pix_we),
    .pix_row   (wr_row),
    .pix_col   (wr_col),
    .pix_color (wr_color),
    .row_we    (b0_row_we),
    .row_addr  (rc),
    .row_data  (row_data),
    .rd_addr_a (upper_row),
    .rd_addr_b (lower_row),
    .rd_data_a (b0_rd_a),
    .rd_data_b (b0_rd_b)
  );

  fb_bank #(
    .NROWS (ROWS),
    .LW    (LW)
  ) u_bank1 (
    .clk       (clk),
    .pix_we    (b1_pix_we),
    .pix_row   (wr_row),
    .pix_col   (wr_col),
    .pix_color (wr_color),
    .row_we    (b1_row_we),
    .row_addr  (rc),
    .row_data  (row_data),
    .rd_addr_a (upper_row),
    .rd_addr_b (lower_row),
    .rd_data_a (b1_rd_a),
    .rd_data_b (b1_rd_b)
  );

  // Controller: INIT and CLEAR both sweep rc over every row, one row per
  // cycle, and return to IDLE after row 31 with rc wrapped back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      rc    <= 5'd0;
      fill  <= '0;
    end else begin
      case (state)
        ST_INIT, ST_CLEAR: begin
          rc <= rc + 5'd1;
          if (rc == 5'd31) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            rc    <= 5'd0;
            fill  <= fill_word(clr_color);
          end
        end
        default: begin
          state <= ST_INIT;
          rc    <= 5'd0;
        end
      endcase
    end
  end

  // Swap bookkeeping: a request can arrive in any state and waits; extra
  // requests while pending fold into the one already latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= commit;
      if (commit) begin
        front_sel <= !front_sel;
        swap_pend <= 1'b0;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

  // Line output registers hold their value between fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      Hline <= '0;
      Lline <= '0;
    end else if (ren) begin
      Hline <= rd_sel ? b1_rd_a : b0_rd_a;
      Lline <= rd_sel ? b1_rd_b : b0_rd_b;
    end
  end

endmodule

// File: tb/tb_board_framebuf.sv
// tb_board_framebuf
// Self-checking bench for board_framebuf: directed table vectors and
// sequences for reset, swap, clear and isolation cases, followed by a
// randomized phase compared every cycle against a behavioural model.
module tb_board_framebuf;
  import disp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ren;
  logic [4:0]  raddr;
  logic [63:0] Hline;
  logic [63:0] Lline;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [4:0]  wr_col;
  logic [1:0]  wr_color;
  logic        clr_req;
  logic [1:0]  clr_color;
  logic        swap_req;
  logic        busy;
  logic        swap_pend;
  logic        swap_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model: two banks of 32 row words, a mode (0 idle, 1 zeroing,
  // 2 filling) with the next row to touch, and the swap/readout state.
  logic [63:0] mbank [2][32];
  int          mmode = 1;
  int          mrow  = 0;
  logic        mfront = 1'b0;
  logic        mpend  = 1'b0;
  logic        mdone  = 1'b0;
  logic [63:0] mfill  = '0;
  logic [63:0] mh     = '0;
  logic [63:0] ml     = '0;

  typedef struct {
    logic        ren;
    logic [4:0]  raddr;
    logic        wr_en;
    logic [4:0]  wr_row;
    logic [4:0]  wr_col;
    logic [1:0]  wr_color;
    logic        swap_req;
    logic        exp_busy;
    logic        exp_pend;
    logic        exp_done;
    logic        chk_lines;
    logic [63:0] exp_h;
    logic [63:0] exp_l;
  } vec_t;

  board_framebuf dut (
    .clk       (clk),
    .rst       (rst),
    .ren       (ren),
    .raddr     (raddr),
    .Hline     (Hline),
    .Lline     (Lline),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_color  (wr_color),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .swap_req  (swap_req),
    .busy      (busy),
    .swap_pend (swap_pend),
    .swap_done (swap_done)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst       = 1'b0;
    ren       = 1'b0;
    raddr     = 5'd0;
    wr_en     = 1'b0;
    wr_row    = 5'd0;
    wr_col    = 5'd0;
    wr_color  = 2'd0;
    clr_req   = 1'b0;
    clr_color = 2'd0;
    swap_req  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic commit;
    logic rbank;
    int   r;
    if (rst) begin
      mmode  = 1;
      mrow   = 0;
      mfront = 1'b0;
      mpend  = 1'b0;
      mdone  = 1'b0;
      mh     = '0;
      ml     = '0;
      return;
    end
    r      = int'(raddr[3:0]);
    commit = (mmode == 0) && mpend && ren && (r == 0);
    rbank  = mfront ^ commit;
    if (ren) begin
      mh = mbank[rbank][r];
      ml = mbank[rbank][r + HALF];
    end
    mdone = commit;
    if (mmode == 1) begin
      mbank[0][mrow] = '0;
      mbank[1][mrow] = '0;
      mrow++;
      if (mrow == 32) begin
        mmode = 0;
        mrow  = 0;
      end
    end else if (mmode == 2) begin
      mbank[!mfront][mrow] = mfill;
      mrow++;
      if (mrow == 32) begin
        mmode = 0;
        mrow  = 0;
      end
    end else if (clr_req) begin
      mmode = 2;
      mrow  = 0;
      mfill = {32{clr_color}};
    end else if (wr_en) begin
      mbank[!mfront][wr_row][2 * int'(wr_col) +: 2] = wr_color;
    end
    if (commit) begin
      mfront = !mfront;
      mpend  = 1'b0;
    end else if (swap_req) begin
      mpend = 1'b1;
    end
  endtask

  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check_line({tag, "_hline"}, Hline, mh);
    check_line({tag, "_lline"}, Lline, ml);
    check_bit({tag, "_busy"}, busy, (mmode != 0));
    check_bit({tag, "_pend"}, swap_pend, mpend);
    check_bit({tag, "_done"}, swap_done, mdone);
  endtask

  initial begin : main
    vec_t vecs[7];
    int   cnt;

    // ren raddr wr_en row col color swap | busy pend done chk  H  L
    vecs[0] = '{1'b0, 5'd0,  1'b1, 5'd3,  5'd0,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 5'd0,  1'b1, 5'd19, 5'd31, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
    vecs[2] = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0};
    vecs[3] = '{1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0};
    vecs[4] = '{1'b1, 5'd3,  1'b0, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                64'h1, 64'hC000_0000_0000_0000};
    vecs[5] = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                64'h1, 64'hC000_0000_0000_0000};
    vecs[6] = '{1'b1, 5'd19, 1'b0, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                64'h1, 64'hC000_0000_0000_0000};

    // Reset held two cycles, then INIT runs for 32 busy cycles.
    idle_inputs();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    check_bit("reset_busy", busy, 1'b1);
    check_bit("reset_pend", swap_pend, 1'b0);
    check_bit("reset_done", swap_done, 1'b0);
    check_line("reset_hline", Hline, 64'h0);
    check_line("reset_lline", Lline, 64'h0);
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      applyStimulus();
      cnt++;
    end
    check_int("init_busy_cycles", cnt, 32);

    ren   = 1'b1;
    raddr = 5'd5;
    applyStimulus();
    idle_inputs();
    check_line("init_read_hline", Hline, 64'h0);
    check_line("init_read_lline", Lline, 64'h0);

    // Pixel writes, swap request, commit at row pair 0, then readback.
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      ren      = vecs[i].ren;
      raddr    = vecs[i].raddr;
      wr_en    = vecs[i].wr_en;
      wr_row   = vecs[i].wr_row;
      wr_col   = vecs[i].wr_col;
      wr_color = vecs[i].wr_color;
      swap_req = vecs[i].swap_req;
      applyStimulus();
      check_bit($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check_bit($sformatf("vec%0d_pend", i), swap_pend, vecs[i].exp_pend);
      check_bit($sformatf("vec%0d_done", i), swap_done, vecs[i].exp_done);
      if (vecs[i].chk_lines) begin
        check_line($sformatf("vec%0d_hline", i), Hline, vecs[i].exp_h);
        check_line($sformatf("vec%0d_lline", i), Lline, vecs[i].exp_l);
      end
    end
    idle_inputs();

    // Double-buffer isolation: back-bank write invisible until the next swap.
    wr_en    = 1'b1;
    wr_row   = 5'd0;
    wr_col   = 5'd1;
    wr_color = 2'b01;
    applyStimulus();
    idle_inputs();
    ren   = 1'b1;
    raddr = 5'd0;
    applyStimulus();
    idle_inputs();
    check_line("iso_front_unchanged", Hline, 64'h0);
    check_bit("iso_no_commit", swap_done, 1'b0);
    swap_req = 1'b1;
    applyStimulus();
    idle_inputs();
    ren   = 1'b1;
    raddr = 5'd0;
    applyStimulus();
    idle_inputs();
    check_bit("iso_swap_done", swap_done, 1'b1);
    check_line("iso_after_swap_hline", Hline, 64'h4);
    check_line("iso_after_swap_lline", Lline, 64'h0);

    // Clear with a colliding pixel write; swap requested and a frame start
    // fetched while busy must wait for the clear to finish.
    clr_req   = 1'b1;
    clr_color = 2'b10;
    wr_en     = 1'b1;
    wr_row    = 5'd5;
    wr_col    = 5'd5;
    wr_color  = 2'b01;
    applyStimulus();
    idle_inputs();
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 3) swap_req = 1'b1;
      if (cnt == 6) begin
        ren   = 1'b1;
        raddr = 5'd0;
      end
      applyStimulus();
      idle_inputs();
      if (cnt == 6) begin
        check_bit("defer_no_commit", swap_done, 1'b0);
        check_bit("defer_pend_held", swap_pend, 1'b1);
        check_line("defer_front_read", Hline, 64'h4);
      end
    end
    check_int("clear_busy_cycles", cnt, 32);
    check_bit("defer_pend_after_clear", swap_pend, 1'b1);
    ren   = 1'b1;
    raddr = 5'd0;
    applyStimulus();
    idle_inputs();
    check_bit("defer_commit", swap_done, 1'b1);
    check_bit("defer_pend_cleared", swap_pend, 1'b0);
    check_line("clear_row0_hline", Hline, 64'hAAAA_AAAA_AAAA_AAAA);
    check_line("clear_row0_lline", Lline, 64'hAAAA_AAAA_AAAA_AAAA);
    for (int r = 1; r < 16; r++) begin
      ren   = 1'b1;
      raddr = 5'(r);
      applyStimulus();
      idle_inputs();
      check_line($sformatf("clear_row%0d_hline", r), Hline, 64'hAAAA_AAAA_AAAA_AAAA);
      check_line($sformatf("clear_row%0d_lline", r), Lline, 64'hAAAA_AAAA_AAAA_AAAA);
    end

    // Reset in the middle of a clear (row 10) with a swap pending.
    swap_req = 1'b1;
    applyStimulus();
    idle_inputs();
    clr_req   = 1'b1;
    clr_color = 2'b11;
    applyStimulus();
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
    end
    check_bit("midclr_busy", busy, 1'b1);
    rst = 1'b1;
    applyStimulus();
    idle_inputs();
    check_bit("midclr_rst_busy", busy, 1'b1);
    check_bit("midclr_rst_pend", swap_pend, 1'b0);
    check_line("midclr_rst_hline", Hline, 64'h0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      applyStimulus();
      cnt++;
    end
    check_int("midclr_init_cycles", cnt, 32);
    for (int r = 0; r < 16; r++) begin
      ren   = 1'b1;
      raddr = 5'(r);
      applyStimulus();
      idle_inputs();
      check_line($sformatf("midclr_row%0d_hline", r), Hline, 64'h0);
      check_line($sformatf("midclr_row%0d_lline", r), Lline, 64'h0);
    end

    // Randomized traffic compared against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      rst   = ($urandom_range(0, 999) == 0);
      ren   = ($urandom_range(0, 9) < 6);
      raddr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) raddr[3:0] = 4'd0;
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_row    = 5'($urandom_range(0, 31));
      wr_col    = 5'($urandom_range(0, 31));
      wr_color  = 2'($urandom_range(0, 3));
      clr_req   = ($urandom_range(0, 199) == 0);
      clr_color = 2'($urandom_range(0, 3));
      swap_req  = ($urandom_range(0, 19) == 0);
      applyStimulus();
      checkOutput($sformatf("rand%0d", n));
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_framebuf.md
# board_framebuf

Double-buffered frame buffer on the responder side of the display line-fetch interface. It serves 64-bit upper and lower line pairs to `display_FSM` (`ren`/`raddr` in, `Hline`/`Lline` out). The Connect-4 game logic writes single pixels into a back bank, can flood-clear it, and requests a bank swap that commits only at a frame boundary.

## Interface
Parameters:
- `ROWS`, 32: panel rows; upper half is rows 0..15, lower half is rows 16..31.
- `COLS`, 32: pixels per row. Each pixel is 2 bits, so a line is 64 bits.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `ren`, in, 1: line read request from `display_FSM`.
- `raddr`, in, 5: row-pair index; only `raddr[3:0]` is used, and `raddr[4]` is ignored.
- `Hline`, out, 64: front-bank row `raddr[3:0]`.
- `Lline`, out, 64: front-bank row `raddr[3:0]+16`.
- `wr_en`, in, 1: pixel write strobe.
- `wr_row`, in, 5: pixel row.
- `wr_col`, in, 5: pixel column.
- `wr_color`, in, 2: color code. 00 off, 01 red, 10 yellow, 11 blue.
- `clr_req`, in, 1: fill the back bank with `clr_color`.
- `clr_color`, in, 2: fill color.
- `swap_req`, in, 1: request a front/back exchange.
- `busy`, out, 1: high during INIT or CLEAR.
- `swap_pend`, out, 1: a swap is latched and not yet committed.
- `swap_done`, out, 1: one-cycle pulse on the swap commit cycle.

## Operation
- Two banks, each 32 rows × 64 bits. `front_sel` picks the bank that serves reads; the other bank is the back bank.
- Pixel packing: column c occupies bits [2c+1:2c] of its row word. Column 0 is at the LSB.
- **FSM states:** INIT, IDLE, CLEAR. A 5-bit row counter `rc` is used by INIT and CLEAR.
- **INIT**
  - Entered on `rst`.
  - Writes 0 to row `rc` of both banks each cycle.
  - After `rc`=31 it goes to IDLE. `rc` wraps to 0.
- **IDLE**
  - `clr_req` → CLEAR with `rc`=0. `clr_color` is latched and replicated ×32 into a 64-bit fill word.
  - Else `wr_en` → the back bank `[wr_row][2*wr_col+1:2*wr_col]` is set to `wr_color` next edge. All other bits are untouched.
- **CLEAR**
  - Writes the fill word into back-bank row `rc` each cycle.
  - After `rc`=31 it goes to IDLE.
  - `clr_req` and `wr_en` are ignored while in CLEAR.
- **Same-cycle collision:** `clr_req` and `wr_en` in IDLE → the clear wins and the write is dropped.
- **Swap**
  - `swap_req` sets `swap_pend` in any state. Repeated requests while pending are absorbed.
  - The swap commits on the first cycle where all of these hold: state is IDLE, `swap_pend`=1, `ren`=1 and `raddr[3:0]`=0.
  - On commit: `front_sel` toggles, `swap_pend` clears and `swap_done` pulses.
  - The read issued on the commit cycle is served from the new front bank.
- **Write on commit cycle:** a `wr_en` in the same cycle as the commit targets the pre-swap back bank, i.e. the bank becoming front.
- **Reads**
  - Front-bank reads work in every state.
  - During INIT, reads return 0 once the addressed rows have been zeroed. Content is deterministic because the output registers are 0 out of reset.
- **Reset mid-operation:** `rst` aborts CLEAR or INIT, restarts INIT with `rc`=0, sets `front_sel`=0 and clears `swap_pend`.

## Timing
- Read latency is 1 cycle.
  - `ren`=1 at edge N → `Hline`/`Lline` valid after edge N and held until the next `ren`.
  - With `ren`=0, the outputs hold their value.
- Pixel write becomes visible in the bank after 1 edge. It is readable from the display only after a swap.
- CLEAR takes 32 cycles from the cycle after `clr_req` is accepted. `busy` is high for exactly those 32 cycles.
- INIT takes 32 cycles after `rst` deasserts, with `busy`=1 throughout.
- Reset values:
  - `Hline`=0, `Lline`=0
  - `busy`=1 (INIT)
  - `swap_pend`=0, `swap_done`=0
  - `front_sel`=0, `rc`=0

## Structure
- `disp_pkg` holds:
  - `color_t` enum: OFF, RED, YEL, BLU.
  - `ROWS`, `COLS`, `LINE_W`=64, `HALF`=16.
  - `fb_state_t` enum: INIT, IDLE, CLEAR.
- Sub-module `fb_bank` is instantiated twice. Each instance is one 32×64 register bank with:
  - a pixel-write port,
  - a full-row write port, shared by INIT and CLEAR,
  - two combinational row-read ports.
- `board_framebuf` holds the FSM, `rc`, the swap logic and the output registers.

## Test plan
- **Reset/INIT:** hold `rst` 2 cycles, release.
  - `busy`=1 for 32 cycles, then 0.
  - `ren`, `raddr`=5 → `Hline`=0, `Lline`=0.
- **Pixel + swap:**
  - Write (row 3, col 0, RED) and (row 19, col 31, BLU), then `swap_req`.
  - `ren` with `raddr`=0 commits the swap and `swap_done` pulses.
  - Then `raddr`=3 → `Hline`=64'h1 and `Lline`=64'hC000_0000_0000_0000.
- **Swap deferral:** `swap_req` during CLEAR, and `ren` with `raddr`=0 while `busy`.
  - No commit yet; `swap_pend` stays 1.
  - Commit happens on the first `raddr`=0 read after CLEAR ends.
- **Clear:** `clr_req` with `clr_color`=YEL plus simultaneous `wr_en`, then swap.
  - Every row reads 64'hAAAA_AAAA_AAAA_AAAA; the write is dropped.
  - `busy` is high exactly 32 cycles.
- **Double-buffer isolation:** after a swap, write row 0 col 1=RED into the back bank.
  - Front-bank reads of row 0 stay unchanged until the next swap.
  - After that swap, bits [3:2] read as 01.
- **Mid-clear reset:** assert `rst` at `rc`=10 of CLEAR.
  - INIT restarts and `front_sel` returns to 0.
  - Afterwards all reads are 0.
